// File: rtl/neuron_mac_datapath_pkg.sv
// neuron_mac_datapath_pkg: shared widths, types and output activation for the neuron MAC datapath
package neuron_mac_datapath_pkg;
  localparam int DATA_W = 8;
  localparam int N = 8;
  localparam int ACC_W = 20;
  localparam int SHIFT = 4;
  localparam int OUT_W = 8;
  localparam int OFF_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 2);
  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [OUT_W-1:0] out_t;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam acc_t OUT_MAX = acc_t'((1 << (OUT_W - 1)) - 1);
  localparam cnt_t CNT_N = cnt_t'(N);
  localparam cnt_t CNT_MAX = cnt_t'(N + 1);
  function automatic out_t relu_sat(acc_t v);
    acc_t s;
    s = v >>> SHIFT;
    return s < 0 ? '0 : s > OUT_MAX ? out_t'(OUT_MAX) : out_t'(s);
  endfunction
endpackage

// File: rtl/weight_regfile.sv
// weight_regfile: N-entry weight register file with async read, plus the bias register
module weight_regfile
  import neuron_mac_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             w_we,
  input  logic [OFF_W-1:0] w_addr,
  input  data_t            w_data,
  input  logic [OFF_W-1:0] rd_addr,
  input  logic             b_we,
  input  acc_t             b_data,
  output data_t            rd_data,
  output acc_t             bias
);
  data_t mem [N];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      bias <= '0;
    end else begin
      if (w_we) mem[w_addr] <= w_data;
      if (b_we) bias <= b_data;
    end
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/neuron_mac_datapath.sv
// neuron_mac_datapath: latches sample/weight, multiply-accumulates, then biases, scales, ReLUs and saturates
module neuron_mac_datapath
  import neuron_mac_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             read,
  input  logic             ld,
  input  logic             ready,
  input  logic [OFF_W-1:0] offset,
  input  data_t            in_data,
  input  logic             w_we,
  input  logic [OFF_W-1:0] w_addr,
  input  data_t            w_data,
  input  logic             b_we,
  input  acc_t             b_data,
  output out_t             out_data,
  output logic             out_valid,
  output logic             term_err
);
  data_t x_reg, w_reg, w_rd;
  acc_t acc, bias;
  cnt_t term_cnt;
  logic signed [2*DATA_W-1:0] prod;
  weight_regfile u_wrf (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .rd_addr(offset), .b_we(b_we), .b_data(b_data), .rd_data(w_rd), .bias(bias)
  );
  assign prod = x_reg * w_reg;
  // ready sees the pre-edge acc/term_cnt, so a coincident start or ld does not affect this output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg <= '0;
      w_reg <= '0;
      acc <= '0;
      term_cnt <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      term_err <= 1'b0;
    end else begin
      if (read) begin
        x_reg <= in_data;
        w_reg <= w_rd;
      end
      if (start) begin
        acc <= '0;
        term_cnt <= '0;
      end else if (ld) begin
        acc <= acc + acc_t'(prod);
        term_cnt <= term_cnt == CNT_MAX ? term_cnt : term_cnt + 1'b1;
      end
      out_valid <= ready;
      if (ready) out_data <= relu_sat(acc + bias);
      if (ready && term_cnt != CNT_N) term_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_neuron_mac_datapath.sv
// tb_neuron_mac_datapath: directed and randomized checks against an integer behavioural model
module tb_neuron_mac_datapath;
  import neuron_mac_datapath_pkg::*;
  logic clk = 0, rst = 0;
  logic start = 0, read = 0, ld = 0, ready = 0, w_we = 0, b_we = 0;
  logic [2:0] offset = 0, w_addr = 0;
  logic signed [7:0] in_data = 0, w_data = 0;
  logic signed [19:0] b_data = 0;
  logic signed [7:0] out_data;
  logic out_valid, term_err;
  int n_cmp = 0, n_fail = 0;
  int m_wt [N];
  int m_bias = 0, m_x = 0, m_w = 0, m_acc = 0, m_cnt = 0, m_out = 0, m_valid = 0, m_err = 0;

  neuron_mac_datapath dut (
    .clk(clk), .rst(rst), .start(start), .read(read), .ld(ld), .ready(ready),
    .offset(offset), .in_data(in_data), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_data(b_data), .out_data(out_data), .out_valid(out_valid), .term_err(term_err)
  );

  always #5 clk = ~clk;

  function automatic int ref_out(int v);
    int s;
    s = v >= 0 ? v / 16 : -((-v + 15) / 16);
    if (s < 0) s = 0;
    if (s > 127) s = 127;
    return s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc = 0; m_cnt = 0; m_x = 0; m_w = 0; m_out = 0; m_valid = 0; m_err = 0; m_bias = 0;
      foreach (m_wt[i]) m_wt[i] = 0;
    end else begin
      m_valid = ready;
      if (ready) begin
        m_out = ref_out(m_acc + m_bias);
        if (m_cnt != N) m_err = 1;
      end
      if (start) begin
        m_acc = 0;
        m_cnt = 0;
      end else if (ld) begin
        m_acc += m_x * m_w;
        if (m_cnt < N + 1) m_cnt++;
      end
      if (read) begin
        m_x = in_data;
        m_w = m_wt[offset];
      end
      if (w_we) m_wt[w_addr] = w_data;
      if (b_we) m_bias = b_data;
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out_data", out_data, m_out);
    chk("out_valid", out_valid, m_valid);
    chk("term_err", term_err, m_err);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_w(int v);
    for (int i = 0; i < N; i++) begin
      w_we = 1; w_addr = 3'(i); w_data = 8'(v);
      step();
    end
    w_we = 0;
  endtask

  task automatic set_b(int v);
    b_we = 1; b_data = 20'(v);
    step();
    b_we = 0;
  endtask

  task automatic term(int x, int off);
    read = 1; offset = 3'(off); in_data = 8'(x);
    step();
    read = 0; ld = 1;
    step();
    ld = 0;
  endtask

  task automatic neuron(int x, int n);
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < n; i++) term(x, i);
    ready = 1;
    step();
    ready = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_out", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", term_err, 0);
    rst = 1;
    step();
    neuron(4, 8);
    chk("zero_out", out_data, 0);
    chk("zero_valid", out_valid, 1);
    chk("zero_err", term_err, 0);
    step();
    chk("zero_valid_drop", out_valid, 0);
    set_w(8);
    neuron(4, 8);
    chk("w8_out", out_data, 16);
    set_b(160);
    neuron(4, 8);
    chk("bias160_out", out_data, 26);
    set_b(0);
    set_w(-8);
    neuron(4, 8);
    chk("relu_out", out_data, 0);
    set_w(16);
    neuron(16, 8);
    chk("sat_out", out_data, 127);
    chk("sat_err", term_err, 0);
    neuron(16, 7);
    chk("short_out", out_data, 112);
    chk("short_err", term_err, 1);
    neuron(16, 8);
    chk("sticky_out", out_data, 127);
    chk("sticky_err", term_err, 1);
    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) term(4, i);
    #2 rst = 0;
    #1;
    chk("midrst_out", out_data, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_err", term_err, 0);
    step();
    rst = 1;
    step();
    set_w(3);
    start = 1; step(); start = 0;
    term(5, 0);
    start = 1; ld = 1; step(); start = 0; ld = 0;
    for (int i = 0; i < 8; i++) term(5, i);
    ready = 1; step(); ready = 0;
    chk("startld_out", out_data, 7);
    chk("startld_err", term_err, 0);
    set_w(0);
    w_we = 1; w_addr = 2; w_data = 10; step(); w_we = 0;
    start = 1; step(); start = 0;
    read = 1; offset = 2; in_data = 16; w_we = 1; w_addr = 2; w_data = 100;
    step();
    read = 0; w_we = 0; ld = 1;
    step();
    ld = 0;
    for (int i = 1; i < 8; i++) term(16, 0);
    ready = 1; step(); ready = 0;
    chk("rdwr_old_out", out_data, 10);
    chk("rdwr_err", term_err, 0);
    for (int k = 0; k < 1500; k++) begin
      start = (k % 24 == 0) || ($urandom_range(0, 7) == 0);
      read = $urandom_range(0, 1) == 1;
      ld = $urandom_range(0, 1) == 1;
      ready = $urandom_range(0, 5) == 0;
      offset = 3'($urandom);
      in_data = 8'($urandom);
      w_we = $urandom_range(0, 7) == 0;
      w_addr = 3'($urandom);
      w_data = 8'($urandom);
      b_we = $urandom_range(0, 15) == 0;
      b_data = 20'(int'($urandom_range(0, 8191)) - 4096);
      step();
    end
    start = 0; read = 0; ld = 0; ready = 0; w_we = 0; b_we = 0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_mac_datapath.md
Name: neuron_mac_datapath

Overview:
- Datapath stage directly downstream of the neuron sequencing controller; consumes its `read`, `ld`, `ready` strobes and 3-bit `offset`.
- On each `read`, latches one input sample and the weight stored at `offset`.
- On each `ld`, multiply-accumulates the latched pair into a signed accumulator.
- On `ready`, adds a bias, scales, applies ReLU and saturation, and registers the neuron output with a one-cycle valid pulse.

Parameters:
- DATA_W, 8, signed width of input samples and weights.
- N, 8, number of input/weight terms per neuron; `offset` width is clog2(N).
- ACC_W, 20, signed accumulator and bias width (must be ≥ 2*DATA_W + clog2(N)).
- SHIFT, 4, arithmetic right shift applied after bias add (fixed-point scaling).
- OUT_W, 8, signed output width; the post-ReLU range is 0 .. 2^(OUT_W-1)-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  new-neuron strobe; clears accumulator and term counter.
- read  in  1  capture `in_data` and weight[`offset`].
- ld  in  1  perform one multiply-accumulate step.
- ready  in  1  finalise: bias, shift, ReLU, saturate, register output.
- offset  in  clog2(N)  term index from controller.
- in_data  in  DATA_W  signed input sample for current term.
- w_we  in  1  weight write enable.
- w_addr  in  clog2(N)  weight write address.
- w_data  in  DATA_W  signed weight write data.
- b_we  in  1  bias write enable.
- b_data  in  ACC_W  signed bias write data.
- out_data  out  OUT_W  registered neuron output, held until next finalise.
- out_valid  out  1  one-cycle pulse, the cycle after `ready`.
- term_err  out  1  sticky flag: `ready` seen with term count ≠ N.

Behaviour:
- Reset (rst=0, async):
  - acc, x_reg, w_reg, term_cnt, out_data, out_valid and term_err all go to 0.
  - Weight RAM (N x DATA_W registers) and bias reset to 0.
- Weight/bias writes:
  - `w_we` writes weight[w_addr] <= w_data; `b_we` writes bias <= b_data.
  - Writes are independent of the strobes.
  - A write to the address being read in the same cycle returns the old value; the new value is visible next cycle.
- `read`: x_reg <= in_data; w_reg <= weight[offset].
- `ld`:
  - acc <= acc + sign_extend(x_reg * w_reg) (full 2*DATA_W signed product).
  - term_cnt <= term_cnt + 1, saturating at N+1.
  - Wrap of acc is not checked; ACC_W sizing guarantees no overflow for N terms.
- `start`:
  - acc <= 0 and term_cnt <= 0. Does not clear out_data or term_err.
  - Priority: if `start` and `ld` coincide, `start` wins (acc=0, term_cnt=0).
- `ready`, evaluated combinationally in the `ready` cycle:
  - s = (acc + bias) >>> SHIFT (arithmetic, floor).
  - r = max(s, 0); o = min(r, 2^(OUT_W-1)-1).
  - Next edge: out_data <= o, out_valid <= 1.
  - If term_cnt ≠ N, term_err <= 1.
  - acc is not cleared by `ready`; only `start` clears it.
- `out_valid`:
  - High for exactly one cycle after each `ready`.
  - Back-to-back `ready` cycles give back-to-back pulses, each with its own value.
- `read` and `ld` in the same cycle: read updates x/w_reg; ld uses the previous x/w_reg. The controller never issues this; it is defined for robustness.
- `term_err` is cleared only by reset.
- Latency:
  - `read` to accumulate: 1 cycle (controller issues `ld` the cycle after `read`).
  - `ready` to `out_valid`: 1 cycle.
- Reset asserted mid-neuron: everything clears immediately; the next neuron requires `start`.

Decomposition:
- Shared package:
  - Localparams DATA_W, ACC_W, OUT_W, SHIFT, N and OFF_W = clog2(N).
  - A function `relu_sat(acc_t) -> out_t`.
  - Typedefs `data_t`, `acc_t`, `out_t`.
- One natural sub-module: `weight_regfile`, holding the N x DATA_W write-port/async-read register file plus the bias register.

Test Plan:
- Reset then all-zero weights: start, 8× (read, ld), ready → out_data=0, out_valid pulse 1 cycle, term_err=0.
- Weights all 8, inputs all 4, bias 0: 8×32=256, >>4 → out_data=16.
- Same with bias=160: (256+160)>>>4 = 26 → out_data=26.
- Weights all -8, inputs 4: acc=-256 → s=-16 → ReLU → out_data=0. Weights 16, inputs 16: 2048>>4=128 → saturate to 127.
- `ready` after only 7 `ld` pulses → term_err=1 and stays 1 through a following correct neuron; out_data still computed from 7 terms.
- rst pulled low between 4th and 5th `ld` → all outputs 0 immediately. Separately: `start` coincident with `ld` → acc=0, term_cnt=0; weight rewrite during `read` of same address → old weight used.
